// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified memory arbiter.
//   state_t    : transaction FSM states (IDLE -> ISSUE -> WAIT -> RESP).
//   GNT_I/D    : grant register encoding (fetch / data).
//   cnt_width  : bits needed to hold a counter value in 0..max_val (minimum 1).
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_arb_prio_starve.sv
// Winner select and anti-starvation counter for the unified memory arbiter.
// Data has fixed priority; once STARVE_MAX data grants have been made while
// a fetch was waiting, the next contended grant goes to fetch.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_req, d_req  : fetch / data requests as seen in IDLE
//   grant_strobe  : a grant is being made this cycle
//   granted_is_d  : the grant being made goes to the data port
//   pick_i        : combinational winner, 1 = fetch wins
module arb_prio_starve
  import unified_mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic d_req,
  input  logic grant_strobe,
  input  logic granted_is_d,
  output logic pick_i
);

  localparam int SW = cnt_width(STARVE_MAX);

  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == SW'(STARVE_MAX));
  assign pick_i  = i_req & (~d_req | starved);

  // Counts only data grants that overtook a waiting fetch; a data grant with
  // no fetch pending is not a starvation event and leaves the count alone.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_strobe) begin
      if (!granted_is_d) begin
        starve_cnt <= '0;
      end else if (i_req && !starved) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Unified memory arbiter: shares one single-port, synchronous-read memory
// between the instruction-fetch and load/store ports, one transaction at a
// time (IDLE sample -> ISSUE strobe -> WAIT MEM_LAT cycles -> RESP pulse).
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   i_req/i_addr                      : fetch request and address
//   i_rdata/i_valid/i_stall           : fetch data, completion pulse, stall
//   d_req/d_we/d_addr/d_wdata         : data request, direction, address, data
//   d_rdata/d_valid/d_stall           : load data, completion pulse, stall
//   m_en/m_we/m_addr/m_wdata/m_rdata  : memory macro interface
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_valid,
  output logic          i_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          d_stall,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  localparam int LW = cnt_width(MEM_LAT - 1);

  state_t          state_q, state_d;
  logic [LW-1:0]   lat_cnt_q;
  logic            lat_last;
  logic            grant_q;
  logic [AW-1:0]   m_addr_q;
  logic            m_we_q;
  logic [DW-1:0]   m_wdata_q;
  logic [DW-1:0]   i_rdata_q;
  logic [DW-1:0]   d_rdata_q;

  logic            any_req;
  logic            grant_strobe;
  logic            pick_i;
  logic            granted_is_d;

  assign any_req      = i_req | d_req;
  assign grant_strobe = (state_q == IDLE) & any_req;
  assign granted_is_d = ~pick_i;
  assign lat_last     = (lat_cnt_q == LW'(MEM_LAT - 1));

  arb_prio_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk          (clk),
    .rst          (rst),
    .i_req        (i_req),
    .d_req        (d_req),
    .grant_strobe (grant_strobe),
    .granted_is_d (granted_is_d),
    .pick_i       (pick_i)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and strobes. Requests are only looked at in IDLE, so a
  // transaction always runs to completion even if its requester drops out.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // skipped an assignment would otherwise infer a latch.
    state_d = state_q;
    m_en    = 1'b0;
    i_valid = 1'b0;
    d_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) state_d = ISSUE;
      end
      ISSUE: begin
        m_en    = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_last) state_d = RESP;
      end
      RESP: begin
        if (grant_q == GNT_I) i_valid = 1'b1;
        else                  d_valid = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: grant, memory command registers, latency counter, read data.
  // The command registers hold between transactions; only m_en qualifies them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q   <= GNT_D;
      m_addr_q  <= '0;
      m_we_q    <= 1'b0;
      m_wdata_q <= '0;
      lat_cnt_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (grant_strobe) begin
        if (pick_i) begin
          grant_q  <= GNT_I;
          m_addr_q <= i_addr;
          m_we_q   <= 1'b0;
        end else begin
          grant_q   <= GNT_D;
          m_addr_q  <= d_addr;
          m_we_q    <= d_we;
          m_wdata_q <= d_wdata;
        end
      end

      if (state_q == ISSUE)     lat_cnt_q <= '0;
      else if (state_q == WAIT) lat_cnt_q <= lat_cnt_q + LW'(1);

      // A write still spends MEM_LAT cycles in WAIT but leaves rdata alone.
      if ((state_q == WAIT) && lat_last && !m_we_q) begin
        if (grant_q == GNT_I) i_rdata_q <= m_rdata;
        else                  d_rdata_q <= m_rdata;
      end
    end
  end

  assign m_addr  = m_addr_q;
  assign m_we    = m_we_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_stall = i_req & ~i_valid;
  assign d_stall = d_req & ~d_valid;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter. Two instances share the clock:
// u_dut (MEM_LAT=1) and u_dut3 (MEM_LAT=3), each with a bench memory that
// drives a sentinel on m_rdata outside the cycle its read data is valid.
// A transaction-level model predicts every output on every cycle; directed
// tests add hand-computed literal expectations.
module tb_unified_mem_arbiter;

  localparam logic [31:0] SENT = 32'hBADBAD00;
  localparam int          SMAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst      = 1'b1;
  logic mem_init = 1'b1;

  // u_dut signals
  logic        i_req = 0, d_req = 0, d_we = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic        i_valid, i_stall, d_valid, d_stall, m_en, m_we;

  // u_dut3 signals
  logic        i_req_3 = 0, d_req_3 = 0, d_we_3 = 0;
  logic [31:0] i_addr_3 = 0, d_addr_3 = 0, d_wdata_3 = 0;
  logic [31:0] i_rdata_3, d_rdata_3, m_addr_3, m_wdata_3, m_rdata_3;
  logic        i_valid_3, i_stall_3, d_valid_3, d_stall_3, m_en_3, m_we_3;

  unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(SMAX)) u_dut3 (
    .clk(clk), .rst(rst),
    .i_req(i_req_3), .i_addr(i_addr_3), .i_rdata(i_rdata_3), .i_valid(i_valid_3), .i_stall(i_stall_3),
    .d_req(d_req_3), .d_we(d_we_3), .d_addr(d_addr_3), .d_wdata(d_wdata_3),
    .d_rdata(d_rdata_3), .d_valid(d_valid_3), .d_stall(d_stall_3),
    .m_en(m_en_3), .m_we(m_we_3), .m_addr(m_addr_3), .m_wdata(m_wdata_3), .m_rdata(m_rdata_3)
  );

  // ---------------------------------------------------------------------------
  // Memory contents and bench memories
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] init_val(input int u, input int i);
    if (u == 0 && i == 0)  return 32'h00000013;
    if (u == 0 && i == 1)  return 32'h00100113;
    if (u == 0 && i == 4)  return 32'h00500093;
    if (u == 1 && i == 32) return 32'hCAFEF00D;
    return 32'h10000000 + 32'(u * 65536) + 32'(i * 4);
  endfunction

  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  logic [31:0] pipe1 [3];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem0[i] <= init_val(0, i);
      m_rdata <= SENT;
    end else begin
      m_rdata <= SENT;
      if (m_en) begin
        if (m_we) mem0[m_addr[9:2]] <= m_wdata;
        else      m_rdata <= mem0[m_addr[9:2]];
      end
    end
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem1[i] <= init_val(1, i);
      for (int j = 0; j < 3; j++) pipe1[j] <= SENT;
    end else begin
      pipe1[0] <= SENT;
      if (m_en_3) begin
        if (m_we_3) mem1[m_addr_3[9:2]] <= m_wdata_3;
        else        pipe1[0] <= mem1[m_addr_3[9:2]];
      end
      pipe1[1] <= pipe1[0];
      pipe1[2] <= pipe1[1];
    end
  end
  assign m_rdata_3 = pipe1[2];

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level model: a grant made in an idle cycle at cycle G puts
  // m_en at G+1 and the valid pulse at G+2+L; the next grant can be made at
  // G+3+L. Arbitration uses a plain integer starve count.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        rst, i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_valid, d_valid, i_stall, d_stall, m_en, m_we;
    logic [31:0] m_addr, m_wdata, i_rdata, d_rdata;
  } snap_t;

  int          cyc = 0;
  bit          busy [2];
  int          t_g [2];
  bit          g_is_i [2];
  bit          g_we [2];
  logic [31:0] g_addr [2], g_wdata [2], g_rdata [2];
  int          starve [2];
  logic [31:0] e_maddr [2], e_mwdata [2], e_irdata [2], e_drdata [2];
  logic        e_mwe [2];
  logic [31:0] ref_mem [2][256];

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  task automatic model_reset(input int u);
    busy[u] = 0; starve[u] = 0;
    e_maddr[u] = '0; e_mwdata[u] = '0; e_irdata[u] = '0; e_drdata[u] = '0; e_mwe[u] = 1'b0;
  endtask

  task automatic model_step(input int u, input snap_t s);
    int  k, L;
    bit  ex_men, ex_iv, ex_dv, pick;
    L = lat_of(u);
    k = 0; ex_men = 0; ex_iv = 0; ex_dv = 0;
    if (busy[u]) begin
      k = cyc - t_g[u];
      ex_men = (k == 1);
      if (k == 2 + L) begin
        if (g_is_i[u]) ex_iv = 1; else ex_dv = 1;
      end
    end
    if (ex_men) begin
      e_maddr[u] = g_addr[u];
      e_mwe[u]   = g_we[u];
      if (!g_is_i[u]) e_mwdata[u] = g_wdata[u];
    end
    if (ex_iv) e_irdata[u] = g_rdata[u];
    if (ex_dv && !g_we[u]) e_drdata[u] = g_rdata[u];

    check($sformatf("u%0d_m_en", u),    s.m_en,    ex_men);
    check($sformatf("u%0d_i_valid", u), s.i_valid, ex_iv);
    check($sformatf("u%0d_d_valid", u), s.d_valid, ex_dv);
    check($sformatf("u%0d_i_stall", u), s.i_stall, s.i_req & ~ex_iv);
    check($sformatf("u%0d_d_stall", u), s.d_stall, s.d_req & ~ex_dv);
    check($sformatf("u%0d_m_addr", u),  s.m_addr,  e_maddr[u]);
    check($sformatf("u%0d_m_we", u),    s.m_we,    e_mwe[u]);
    check($sformatf("u%0d_m_wdata", u), s.m_wdata, e_mwdata[u]);
    check($sformatf("u%0d_i_rdata", u), s.i_rdata, e_irdata[u]);
    check($sformatf("u%0d_d_rdata", u), s.d_rdata, e_drdata[u]);
    // A requester must hold its request until its valid pulse.
    if (busy[u] && !s.rst && k < 2 + L)
      check($sformatf("u%0d_req_held", u), g_is_i[u] ? s.i_req : s.d_req, 1'b1);

    if (s.rst) begin
      model_reset(u);
    end else if (busy[u]) begin
      if (k == 2 + L) busy[u] = 0;
    end else if (s.i_req || s.d_req) begin
      pick = s.i_req && (!s.d_req || starve[u] == SMAX);
      if (pick)          starve[u] = 0;
      else if (s.i_req)  starve[u] = (starve[u] < SMAX) ? starve[u] + 1 : SMAX;
      busy[u]   = 1;
      t_g[u]    = cyc;
      g_is_i[u] = pick;
      if (pick) begin
        g_addr[u]  = s.i_addr;
        g_we[u]    = 0;
        g_rdata[u] = ref_mem[u][s.i_addr[9:2]];
      end else begin
        g_addr[u]  = s.d_addr;
        g_we[u]    = s.d_we;
        g_wdata[u] = s.d_wdata;
        if (s.d_we) ref_mem[u][s.d_addr[9:2]] = s.d_wdata;
        else        g_rdata[u] = ref_mem[u][s.d_addr[9:2]];
      end
    end
  endtask

  always @(negedge clk) begin
    snap_t s0, s1;
    s0.rst = rst; s0.i_req = i_req; s0.d_req = d_req; s0.d_we = d_we;
    s0.i_addr = i_addr; s0.d_addr = d_addr; s0.d_wdata = d_wdata;
    s0.i_valid = i_valid; s0.d_valid = d_valid; s0.i_stall = i_stall; s0.d_stall = d_stall;
    s0.m_en = m_en; s0.m_we = m_we; s0.m_addr = m_addr; s0.m_wdata = m_wdata;
    s0.i_rdata = i_rdata; s0.d_rdata = d_rdata;
    s1.rst = rst; s1.i_req = i_req_3; s1.d_req = d_req_3; s1.d_we = d_we_3;
    s1.i_addr = i_addr_3; s1.d_addr = d_addr_3; s1.d_wdata = d_wdata_3;
    s1.i_valid = i_valid_3; s1.d_valid = d_valid_3; s1.i_stall = i_stall_3; s1.d_stall = d_stall_3;
    s1.m_en = m_en_3; s1.m_we = m_we_3; s1.m_addr = m_addr_3; s1.m_wdata = m_wdata_3;
    s1.i_rdata = i_rdata_3; s1.d_rdata = d_rdata_3;
    model_step(0, s0);
    model_step(1, s1);
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after a rising edge; direct
  // checks sample 4 units after it.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic run_i(input logic [31:0] addr, output logic [31:0] rdata, output int lat);
    i_req = 1; i_addr = addr; lat = -1; rdata = '0;
    for (int k = 0; k < 20; k++) begin
      settle();
      if (i_valid) begin
        lat = k; rdata = i_rdata;
        step();
        break;
      end
      step();
    end
    i_req = 0;
  endtask

  task automatic run_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output int lat,
                       output logic men_we, output logic [31:0] men_wdata);
    d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
    lat = -1; rdata = '0; men_we = 0; men_wdata = '0;
    for (int k = 0; k < 20; k++) begin
      settle();
      if (m_en) begin men_we = m_we; men_wdata = m_wdata; end
      if (d_valid) begin
        lat = k; rdata = d_rdata;
        step();
        break;
      end
      step();
    end
    d_req = 0;
  endtask

  task automatic run_d3(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int lat, output int men_k);
    d_req_3 = 1; d_we_3 = we; d_addr_3 = addr; d_wdata_3 = wdata;
    lat = -1; men_k = -1; rdata = '0;
    for (int k = 0; k < 20; k++) begin
      settle();
      if (m_en_3 && men_k < 0) men_k = k;
      if (d_valid_3) begin
        lat = k; rdata = d_rdata_3;
        step();
        break;
      end
      step();
    end
    d_req_3 = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_en"},    m_en,    1'b0);
    check({tag, "_m_we"},    m_we,    1'b0);
    check({tag, "_m_addr"},  m_addr,  32'h0);
    check({tag, "_m_wdata"}, m_wdata, 32'h0);
    check({tag, "_i_valid"}, i_valid, 1'b0);
    check({tag, "_d_valid"}, d_valid, 1'b0);
    check({tag, "_i_stall"}, i_stall, 1'b0);
    check({tag, "_d_stall"}, d_stall, 1'b0);
    check({tag, "_i_rdata"}, i_rdata, 32'h0);
    check({tag, "_d_rdata"}, d_rdata, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] rd, mwd;
    logic        mwe;
    int          lat, men_k;
    logic [9:0]  order;
    logic [9:0]  exp_order;
    int          n, nv, nm, men_cnt, last_men;
    int          vt [2], men_t [2];
    logic [31:0] vr [2], men_a [2];

    for (int u = 0; u < 2; u++) begin
      model_reset(u);
      for (int i = 0; i < 256; i++) ref_mem[u][i] = init_val(u, i);
    end

    // Power-on reset
    #1;
    repeat (3) step();
    settle();
    check_all_zero("rst0");
    check("rst0_u3_m_en", m_en_3, 1'b0);
    rst = 0; mem_init = 0;
    step();

    // Single fetch at 0x10
    i_req = 1; i_addr = 32'h10;
    for (int k = 0; k <= 4; k++) begin
      settle();
      check($sformatf("t1_m_en_k%0d", k), m_en, k == 1);
      if (k == 1) begin
        check("t1_m_addr", m_addr, 32'h10);
        check("t1_m_we",   m_we,   1'b0);
      end
      check($sformatf("t1_i_valid_k%0d", k), i_valid, k == 3);
      if (k == 3) check("t1_i_rdata", i_rdata, 32'h00500093);
      check($sformatf("t1_i_stall_k%0d", k), i_stall, k < 3);
      step();
      if (k == 3) i_req = 0;
    end

    // Data write then read
    run_d(1'b1, 32'h40, 32'hDEADBEEF, rd, lat, mwe, mwd);
    check("t2_wr_lat",   lat, 3);
    check("t2_wr_m_we",  mwe, 1'b1);
    check("t2_wr_wdata", mwd, 32'hDEADBEEF);
    run_d(1'b0, 32'h40, 32'h0, rd, lat, mwe, mwd);
    check("t2_rd_lat",   lat, 3);
    check("t2_rd_m_we",  mwe, 1'b0);
    check("t2_rd_data",  rd,  32'hDEADBEEF);

    // Contention: both requests held high for ten grants
    i_req = 1; i_addr = 32'h0;
    d_req = 1; d_we = 0; d_addr = 32'h40;
    order = '0; n = 0; men_cnt = 0; last_men = -100;
    for (int k = 0; k < 60 && n < 10; k++) begin
      settle();
      if (m_en) begin
        if (men_cnt > 0) check("t3_m_en_gap_ge4", (k - last_men) >= 4, 1'b1);
        last_men = k; men_cnt++;
      end
      if (i_valid || d_valid) begin
        check("t3_single_valid", i_valid & d_valid, 1'b0);
        order[9 - n] = i_valid;
        n++;
      end
      step();
      if (n == 10) begin i_req = 0; d_req = 0; end
    end
    i_req = 0; d_req = 0;
    exp_order = 10'b0000100001;
    check("t3_grant_order", order, exp_order);
    check("t3_valid_count", n, 10);
    check("t3_m_en_count", men_cnt, 10);

    // Back-to-back fetch: 0x0 then 0x4 with i_req held through the pulse
    step();
    i_req = 1; i_addr = 32'h0;
    nv = 0; nm = 0;
    for (int j = 0; j < 2; j++) begin vt[j] = -1; men_t[j] = -1; vr[j] = '0; men_a[j] = '0; end
    for (int k = 0; k < 20 && nv < 2; k++) begin
      settle();
      if (m_en && nm < 2) begin men_t[nm] = k; men_a[nm] = m_addr; nm++; end
      if (i_valid && nv < 2) begin vt[nv] = k; vr[nv] = i_rdata; nv++; end
      step();
      if (nv == 1 && i_addr == 32'h0) i_addr = 32'h4;
      if (nv == 2) i_req = 0;
    end
    i_req = 0;
    check("t4_m_en0_at",   men_t[0], 1);
    check("t4_m_en1_at",   men_t[1], 5);
    check("t4_m_addr1",    men_a[1], 32'h4);
    check("t4_valid0_at",  vt[0], 3);
    check("t4_valid1_at",  vt[1], 7);
    check("t4_rdata0",     vr[0], 32'h00000013);
    check("t4_rdata1",     vr[1], 32'h00100113);

    // Reset in the WAIT cycle of a fetch
    step();
    i_req = 1; i_addr = 32'h10;
    settle(); step();                 // T: IDLE grant
    settle(); check("t5_m_en_issue", m_en, 1'b1); step();   // T+1: ISSUE
    rst = 1; i_req = 0;               // T+2: WAIT, reset sampled at its end
    settle(); check("t5_no_valid_wait", i_valid, 1'b0);
    step();
    rst = 0;                          // T+3: after reset
    settle();
    check_all_zero("t5_post");
    step();
    run_i(32'h10, rd, lat);
    check("t5_refetch_lat",   lat, 3);
    check("t5_refetch_rdata", rd,  32'h00500093);

    // MEM_LAT=3 instance: read, then write and read back
    run_d3(1'b0, 32'h80, 32'h0, rd, lat, men_k);
    check("t6_m_en_at",  men_k, 1);
    check("t6_valid_at", lat, 5);
    check("t6_rdata",    rd, 32'hCAFEF00D);
    run_d3(1'b1, 32'h84, 32'h12345678, rd, lat, men_k);
    check("t6_wr_valid_at", lat, 5);
    check("t6_wr_keeps_rdata", rd, 32'hCAFEF00D);
    run_d3(1'b0, 32'h84, 32'h0, rd, lat, men_k);
    check("t6_rd2_rdata", rd, 32'h12345678);

    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
